aes_block_buffer: RTL and testbench
===================================

# aes_block_buffer

Parametrised successor to the fixed 4-word receive shift register on the AES datapath. It assembles a stream of WORD_W-bit words from the AHB side into BLOCK_W-bit AES blocks and queues up to DEPTH complete blocks. The queue feeds the AES round controller through a valid/ready handshake and carries a last-block marker for the top-level controller. It sits between the AHB slave data path and the AES round controller.

## Interface
- WORD_W, 32, input word width; BLOCK_W must be an integer multiple of it.
- BLOCK_W, 128, block width.
- DEPTH, 4, number of queued complete blocks; must be at least 2; need not be a power of 2.
- Derived: W = BLOCK_W/WORD_W, which must be at least 2. CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronously discards the partial block and all queued blocks.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  buffer can accept a word.
- in_word  in  WORD_W  input word; the first word of a block is most significant.
- in_last  in  1  the accepted word is the final word of the message.
- out_valid  out  1  head block is valid.
- out_ready  in  1  consumer takes the head block.
- out_block  out  BLOCK_W  head block; 0 when out_valid=0.
- out_last  out  1  head block is the message's last block; 0 when out_valid=0.
- count  out  CW  number of queued complete blocks.
- err  out  1  sticky error flag (see Configuration).

## Operation
- Word accept: in_valid && in_ready.
  - The word is written to the assembly register at slot word_cnt. Slot 0 is bits [BLOCK_W-1 -: WORD_W].
  - word_cnt increments.
- Block commit happens on accept when word_cnt==W-1, or when in_last=1.
  - {assembly, in_word, in_last} is pushed into the FIFO at wr_ptr.
  - word_cnt returns to 0.
  - The assembly register is cleared to 0.
- in_ready = (count < DEPTH). It has no combinational dependence on out_ready.
- Pop: out_valid && out_ready. rd_ptr advances.
- Pointers wrap from DEPTH-1 to 0.
- Count update when push and pop happen in the same cycle: count is unchanged and both pointers advance.
- Priority: rst > flush > push/pop.
- flush:
  - word_cnt, both pointers and count go to 0.
  - The assembly register is cleared.
  - err is not cleared; only rst clears err.
  - A word presented in the same cycle as flush is dropped.
- FIFO storage: a register array. Reading is combinational from the rd_ptr entry, gated by out_valid.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_block=0, out_last=0, count=0, err=0.
  - word_cnt=0, pointers=0.
- Latency: when the final word of a block is accepted at edge N, out_valid=1 and count is incremented from edge N onward.
- Full condition (count==DEPTH):
  - in_ready=0.
  - A pop in that cycle raises in_ready after the next edge, not in the same cycle.
- Empty condition (count==0):
  - out_valid=0.
  - out_ready is ignored.
- out_block and out_last are stable while out_valid=1 && out_ready=0.
- A reset or flush applied mid-block or mid-queue empties the buffer at the next edge; no partial data survives.
- Throughput: one word per cycle sustained. One block per W cycles when the consumer pops promptly.

## Configuration
- AES_BUF_PAD_EN defined:
  - in_last on a word with word_cnt < W-1 commits a partial block.
  - The unfilled low slots are zero-padded.
  - out_last=1 on that block.
  - err is never set.
- AES_BUF_PAD_EN undefined:
  - in_last on a word with word_cnt < W-1 sets err=1, sticky until rst.
  - The partial block and that word are discarded: no push, and word_cnt returns to 0.
  - in_last on a word with word_cnt==W-1 commits normally with out_last=1.

## Test plan
- Basic assembly, default parameters:
  - Stimulus: words abcd52c2, f9c6f303, 030f8303, 1ab61040 on consecutive cycles, the last with in_last=1.
  - Required response: one cycle later out_valid=1, out_block=128'habcd52c2f9c6f303030f83031ab61040, out_last=1, count=1.
  - Then out_ready=1 for one cycle gives count=0 and out_valid=0.
- Full and back-pressure:
  - Stimulus: push 4 blocks with out_ready=0.
  - Required response: count=4 and in_ready=0, and a 17th in_valid word is not accepted.
  - Stimulus: pop once.
  - Required response: in_ready=1 on the following cycle, and blocks emerge in push order across the pointer wrap.
- Simultaneous push and pop:
  - Stimulus: with count=2, complete a block in the same cycle as a pop.
  - Required response: count stays 2.
- Flush mid-block:
  - Stimulus: 2 words accepted and 1 block queued, then flush=1 with in_valid=1.
  - Required response: next cycle count=0, out_valid=0.
  - The next 4 words form a clean block whose first word is in the MSBs.
- Partial last word, macro defined:
  - Stimulus: 2 words 11111111, 22222222, the second with in_last=1.
  - Required response: out_block=128'h11111111222222220000000000000000, out_last=1.
- Partial last word, macro undefined:
  - Stimulus: the same sequence.
  - Required response: err=1, count=0.
  - rst clears err.
- Parametrised instance:
  - Stimulus: WORD_W=64, DEPTH=3, two words per block.
  - Required response: count saturates at 3 and block order is preserved through the wrap.

Source files
------------

// File: rtl/aes_block_buffer.sv
// Assembles WORD_W-bit words into BLOCK_W-bit AES blocks and queues up to DEPTH of them.
// Define AES_BUF_PAD_EN to zero-pad short final blocks instead of flagging them as errors.
module aes_block_buffer #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W-1:0]          in_word,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLOCK_W-1:0]         out_block,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int W   = BLOCK_W / WORD_W;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WCW = $clog2(W);
    localparam int PW  = $clog2(DEPTH);

    logic [BLOCK_W-1:0] r_assembly;
    logic [WCW-1:0]     r_word_cnt;
    logic [BLOCK_W-1:0] r_mem [DEPTH];
    logic               r_last_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_err;

    logic [BLOCK_W-1:0] w_merged;
    logic               w_accept;
    logic               w_at_end;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_accept  = in_valid && in_ready;
    assign w_at_end  = (r_word_cnt == WCW'(W - 1));
    assign w_pop     = out_valid && out_ready;

`ifdef AES_BUF_PAD_EN
    // Cleared assembly slots provide the zero padding for a short final block.
    assign w_push = w_accept && (w_at_end || in_last);
    assign w_drop = 1'b0;
`else
    assign w_push = w_accept && w_at_end;
    assign w_drop = w_accept && in_last && !w_at_end;
`endif

    always_comb begin
        w_merged = r_assembly;
        for (int i = 0; i < W; i++) begin
            if (r_word_cnt == WCW'(i)) begin
                w_merged[BLOCK_W-1-i*WORD_W -: WORD_W] = in_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_assembly <= '0;
            r_word_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else if (flush) begin
            r_assembly <= '0;
            r_word_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                if (w_push || w_drop) begin
                    r_word_cnt <= '0;
                    r_assembly <= '0;
                end else begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_assembly <= w_merged;
                end
            end
            if (w_push) begin
                r_wr_ptr <= nextPtr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= nextPtr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_mem[r_wr_ptr]      <= w_merged;
            r_last_mem[r_wr_ptr] <= in_last;
        end
    end

    assign out_block = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_last  = out_valid ? r_last_mem[r_rd_ptr] : 1'b0;
    assign count     = r_count;
    assign err       = r_err;

endmodule

// File: tb/tb_aes_block_buffer.sv
// Directed bench for aes_block_buffer: default instance plus a 64-bit-word, depth-3 instance.
module tb_aes_block_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         inValid;
    logic         inReady;
    logic [31:0]  inWord;
    logic         inLast;
    logic         outValid;
    logic         outReady;
    logic [127:0] outBlock;
    logic         outLast;
    logic [2:0]   count;
    logic         err;

    logic         flush2;
    logic         inValid2;
    logic         inReady2;
    logic [63:0]  inWord2;
    logic         inLast2;
    logic         outValid2;
    logic         outReady2;
    logic [127:0] outBlock2;
    logic         outLast2;
    logic [1:0]   count2;
    logic         err2;

    int errorCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    aes_block_buffer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_word(inWord), .in_last(inLast),
        .out_valid(outValid), .out_ready(outReady), .out_block(outBlock),
        .out_last(outLast), .count(count), .err(err)
    );

    aes_block_buffer #(.WORD_W(64), .BLOCK_W(128), .DEPTH(3)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(inValid2), .in_ready(inReady2), .in_word(inWord2), .in_last(inLast2),
        .out_valid(outValid2), .out_ready(outReady2), .out_block(outBlock2),
        .out_last(outLast2), .count(count2), .err(err2)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] word, input logic last);
        inValid = 1'b1;
        inWord  = word;
        inLast  = last;
        step();
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic applyStimulus2(input logic [63:0] word);
        inValid2 = 1'b1;
        inWord2  = word;
        step();
        inValid2 = 1'b0;
    endtask

    task automatic popOnce();
        outReady = 1'b1;
        step();
        outReady = 1'b0;
    endtask

    task automatic popOnce2();
        outReady2 = 1'b1;
        step();
        outReady2 = 1'b0;
    endtask

    function automatic logic [31:0] fullWord(input int k, input int j);
        return 32'hB000_0000 | 32'(k << 8) | 32'(j);
    endfunction

    function automatic logic [127:0] fullBlock(input int k);
        return {fullWord(k, 0), fullWord(k, 1), fullWord(k, 2), fullWord(k, 3)};
    endfunction

    function automatic logic [63:0] wideWord(input int k, input int j);
        return 64'hC0DE_0000_0000_0000 | 64'(k << 8) | 64'(j);
    endfunction

    task automatic pushFullBlock(input int k);
        for (int j = 0; j < 4; j++) applyStimulus(fullWord(k, j), 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inWord = '0; inLast = 1'b0; outReady = 1'b0;
        flush2 = 1'b0; inValid2 = 1'b0; inWord2 = '0; inLast2 = 1'b0; outReady2 = 1'b0;
        step();
        step();
        rst = 1'b0;

        checkOutput("rst in_ready", 128'(inReady), 128'd1);
        checkOutput("rst out_valid", 128'(outValid), 128'd0);
        checkOutput("rst out_block", outBlock, 128'd0);
        checkOutput("rst out_last", 128'(outLast), 128'd0);
        checkOutput("rst count", 128'(count), 128'd0);
        checkOutput("rst err", 128'(err), 128'd0);

        // Basic assembly
        applyStimulus(32'habcd52c2, 1'b0);
        applyStimulus(32'hf9c6f303, 1'b0);
        applyStimulus(32'h030f8303, 1'b0);
        applyStimulus(32'h1ab61040, 1'b1);
        checkOutput("basic out_valid", 128'(outValid), 128'd1);
        checkOutput("basic out_block", outBlock, 128'habcd52c2f9c6f303030f83031ab61040);
        checkOutput("basic out_last", 128'(outLast), 128'd1);
        checkOutput("basic count", 128'(count), 128'd1);
        popOnce();
        checkOutput("basic pop count", 128'(count), 128'd0);
        checkOutput("basic pop out_valid", 128'(outValid), 128'd0);

        // Full and back-pressure across the pointer wrap
        for (int k = 0; k < 4; k++) pushFullBlock(k);
        checkOutput("full count", 128'(count), 128'd4);
        checkOutput("full in_ready", 128'(inReady), 128'd0);
        checkOutput("full out_last", 128'(outLast), 128'd0);
        applyStimulus(32'hDEADBEEF, 1'b0);
        checkOutput("full 17th count", 128'(count), 128'd4);
        checkOutput("full head", outBlock, fullBlock(0));
        outReady = 1'b1;
        #1;
        checkOutput("full in_ready during pop", 128'(inReady), 128'd0);
        step();
        outReady = 1'b0;
        checkOutput("full in_ready after pop", 128'(inReady), 128'd1);
        checkOutput("full count after pop", 128'(count), 128'd3);
        pushFullBlock(4);
        checkOutput("wrap count", 128'(count), 128'd4);
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("wrap order %0d", k), outBlock, fullBlock(k));
            popOnce();
        end
        checkOutput("wrap drained", 128'(outValid), 128'd0);

        // Simultaneous push and pop
        pushFullBlock(5);
        pushFullBlock(6);
        for (int j = 0; j < 3; j++) applyStimulus(fullWord(7, j), 1'b0);
        outReady = 1'b1;
        applyStimulus(fullWord(7, 3), 1'b0);
        outReady = 1'b0;
        checkOutput("pushpop count", 128'(count), 128'd2);
        checkOutput("pushpop head", outBlock, fullBlock(6));
        popOnce();
        checkOutput("pushpop tail", outBlock, fullBlock(7));
        popOnce();

        // Flush mid-block
        pushFullBlock(8);
        applyStimulus(fullWord(9, 0), 1'b0);
        applyStimulus(fullWord(9, 1), 1'b0);
        flush = 1'b1;
        applyStimulus(32'h5555AAAA, 1'b0);
        flush = 1'b0;
        checkOutput("flush count", 128'(count), 128'd0);
        checkOutput("flush out_valid", 128'(outValid), 128'd0);
        checkOutput("flush out_block", outBlock, 128'd0);
        pushFullBlock(10);
        checkOutput("flush clean block", outBlock, fullBlock(10));
        checkOutput("flush clean count", 128'(count), 128'd1);
        popOnce();

        // Partial final block
        applyStimulus(32'h11111111, 1'b0);
        applyStimulus(32'h22222222, 1'b1);
`ifdef AES_BUF_PAD_EN
        checkOutput("pad out_valid", 128'(outValid), 128'd1);
        checkOutput("pad out_block", outBlock, 128'h11111111222222220000000000000000);
        checkOutput("pad out_last", 128'(outLast), 128'd1);
        checkOutput("pad err", 128'(err), 128'd0);
        popOnce();
`else
        checkOutput("partial err", 128'(err), 128'd1);
        checkOutput("partial count", 128'(count), 128'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("partial err after flush", 128'(err), 128'd1);
`endif
        pushFullBlock(11);
        checkOutput("after partial block", outBlock, fullBlock(11));
        checkOutput("after partial last", 128'(outLast), 128'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst clears err", 128'(err), 128'd0);
        checkOutput("rst clears count", 128'(count), 128'd0);

        // Parametrised instance: 64-bit words, depth 3
        for (int k = 0; k < 3; k++) begin
            applyStimulus2(wideWord(k, 0));
            applyStimulus2(wideWord(k, 1));
        end
        checkOutput("p64 count sat", 128'(count2), 128'd3);
        checkOutput("p64 in_ready", 128'(inReady2), 128'd0);
        applyStimulus2(64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("p64 extra rejected", 128'(count2), 128'd3);
        checkOutput("p64 head", outBlock2, {wideWord(0, 0), wideWord(0, 1)});
        popOnce2();
        applyStimulus2(wideWord(3, 0));
        applyStimulus2(wideWord(3, 1));
        checkOutput("p64 wrap count", 128'(count2), 128'd3);
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("p64 order %0d", k), outBlock2, {wideWord(k, 0), wideWord(k, 1)});
            popOnce2();
        end
        checkOutput("p64 drained", 128'(outValid2), 128'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
